// File: rtl/secuenciador_fir.sv
// FIR sequencer: holds a TAPS-deep sample delay line and steps an external MAC unit one tap per clock.
// Strobe to salida_vld is TAPS+2 cycles; strobes arriving while busy are dropped and flagged in overrun.
module secuenciador_fir #(
  parameter int N    = 25,
  parameter int TAPS = 8,
  parameter int CW   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        muestra_in,
  input  logic                muestra_vld,
  input  logic [TAPS*N-1:0]   coef_bus,
  output logic [N-1:0]        Multip_G,
  output logic [N-1:0]        Constantes_G,
  output logic [N-1:0]        Entrada_G,
  input  logic [N-1:0]        Valores,
  output logic [N-1:0]        salida,
  output logic                salida_vld,
  output logic                ocupado,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, CARGA, MAC, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    d_q [TAPS];
  logic [N-1:0]    d_d [TAPS];
  logic [N-1:0]    salida_q, salida_d;
  logic            salida_vld_q, salida_vld_d;
  logic            ocupado_q, ocupado_d;
  logic            overrun_q, overrun_d;

  logic [N-1:0]    mult_sel, coef_sel;
  logic            active;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    d_d          = d_q;
    salida_d     = salida_q;
    salida_vld_d = 1'b0;
    ocupado_d    = ocupado_q;
    overrun_d    = overrun_q | (muestra_vld && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        ocupado_d = 1'b0;
        if (muestra_vld) begin
          d_d[0] = muestra_in;
          for (int i = 1; i < TAPS; i++) d_d[i] = d_q[i-1];
          acc_d     = '0;
          k_d       = '0;
          ocupado_d = 1'b1;
          state_d   = CARGA;
        end
      end
      CARGA: state_d = MAC;
      MAC: begin
        acc_d = Valores;
        if (k_q == CW'(TAPS-1)) begin
          // The final MAC return is the filtered sample; it is captured here so it is
          // already on salida during the FIN cycle that carries salida_vld.
          k_d          = '0;
          salida_d     = Valores;
          salida_vld_d = 1'b1;
          state_d      = FIN;
        end else if (k_q < CW'(TAPS-1)) begin
          k_d = k_q + CW'(1);
        end else begin
          k_d       = '0;
          ocupado_d = 1'b0;
          state_d   = IDLE;
        end
      end
      FIN: begin
        ocupado_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        k_d       = '0;
        ocupado_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      acc_q        <= '0;
      for (int i = 0; i < TAPS; i++) d_q[i] <= '0;
      salida_q     <= '0;
      salida_vld_q <= 1'b0;
      ocupado_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      d_q          <= d_d;
      salida_q     <= salida_d;
      salida_vld_q <= salida_vld_d;
      ocupado_q    <= ocupado_d;
      overrun_q    <= overrun_d;
    end
  end

  // Operands come straight from registered state so the MAC unit sees tap k in the cycle k is held.
  always_comb begin
    mult_sel = '0;
    coef_sel = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (k_q == CW'(i)) begin
        mult_sel = d_q[i];
        coef_sel = coef_bus[i*N +: N];
      end
    end
    active = (state_q == CARGA) || (state_q == MAC);
  end

  assign Multip_G     = active ? mult_sel : '0;
  assign Constantes_G = active ? coef_sel : '0;
  assign Entrada_G    = active ? acc_q    : '0;
  assign salida       = salida_q;
  assign salida_vld   = salida_vld_q;
  assign ocupado      = ocupado_q;
  assign overrun      = overrun_q;

endmodule
